plab4_net_router_input_ctrl_sep: RTL and testbench
==================================================

# plab4_net_router_input_ctrl_sep

Per-input-port buffer and route-compute stage of the ring router, directly upstream of the per-output arbitration controls. It queues incoming messages with their 1-bit security domain, computes the output port for the head message, and raises exactly one of three separate request wires (prev, terminal, next). It dequeues when the matching grant returns, and drives the head message, its domain and a valid flag toward the crossbar.

## Interface
- p_msg_nbits, 16, message width; destination field occupies the top p_dest_nbits bits
- p_dest_nbits, 2, destination router-id width
- p_num_routers, 4, routers on the ring
- p_router_id, 0, id of the router containing this block
- p_num_entries, 2, queue depth (≥2)
- clk  input  1  clock; one clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  upstream message valid
- in_rdy  output  1  queue can accept
- in_msg  input  p_msg_nbits  incoming message
- in_domain  input  1  domain of incoming message
- reqs_p0  output  1  request to prev-port output ctrl
- reqs_p1  output  1  request to terminal-port output ctrl
- reqs_p2  output  1  request to next-port output ctrl
- grants_p0  input  1  grant from prev-port output ctrl
- grants_p1  input  1  grant from terminal-port output ctrl
- grants_p2  input  1  grant from next-port output ctrl
- head_msg  output  p_msg_nbits  head entry toward crossbar
- head_domain  output  1  domain of head entry; 0 when empty
- head_val  output  1  queue non-empty

## Operation
- Circular queue of p_num_entries entries {msg, domain}, with head/tail pointers and an occupancy count 0..p_num_entries. Pointers wrap from p_num_entries-1 to 0.
- Enqueue on in_val && in_rdy. in_rdy = (count != p_num_entries); in_rdy is not raised on a same-cycle dequeue.
- Route for head: dest = head_msg[p_msg_nbits-1 -: p_dest_nbits]; fwd = (dest - p_router_id) mod p_num_routers.
  - fwd == 0 → p1.
  - 0 < fwd ≤ p_num_routers/2 → p2 (ties go forward).
  - Otherwise → p0.
- Requests: when head_val, exactly one of reqs_p0..p2 is high per the route; all are low when empty. A request stays asserted and stable until granted.
- Dequeue when grants_pX && reqs_pX for the requested X. A grant on a non-requested port is ignored. More than one simultaneous grant is illegal; the requested port's grant is the only one honoured.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full: in_val is held off with no loss. Empty: grants are ignored.
- Reset mid-operation flushes all entries. Queued messages are dropped.

## Timing
- Reset values: count 0, pointers 0, head_val 0, reqs_p0..p2 0, head_domain 0, head_msg 0. in_rdy is 0 while reset is high and 1 on the first cycle after.
- Enqueue-to-request latency is 1 cycle: an entry written at edge N into an empty queue requests in cycle N+1.
- Grant at cycle N pops at edge N+1. The next entry's request appears in cycle N+1, so back-to-back throughput is 1 message per cycle.
- reqs, head_val, head_msg and head_domain are decoded combinationally from registered state only. There is no combinational path from grants to reqs.
- in_rdy depends only on registered count.

## Configuration
- PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN defined:
  - When the queue is empty and in_val is high, the incoming message drives head_msg, head_domain, head_val and the reqs in the same cycle (0-cycle latency).
  - If granted in that cycle it is consumed without being written.
  - If not granted it is enqueued normally.
  - With bypass, reqs do depend combinationally on in_val/in_msg.
- Undefined: 1-cycle latency as in Timing.

## Structure
- Shared package holds:
  - port index constants PORT_PREV=0, PORT_TERM=1, PORT_NEXT=2;
  - the destination-field extraction function;
  - the ring-distance route function, so the output controls and the crossbar decode share one definition.
- Natural sub-module: plab4_net_router_input_queue, the storage, pointers and count with enq/deq, full/empty and the head read port. Route compute, request generation and dequeue logic stay in this block.

## Test plan
- Reset, then enqueue msg with dest=0 at p_router_id=0 → the next cycle reqs_p1=1, reqs_p0=reqs_p2=0. Grant p1 → head_val=0 the next cycle.
- With N=4, id=0, enqueue dests 1, 2, 3 in turn and grant each → requests appear on p2, p2, p0 respectively; dest 2 exercises the forward tie-break.
- Fill 2 entries without grants → in_rdy=0, and a third in_val is held without loss. Grant → the next cycle in_rdy=1 and the second entry requests.
- Enqueue domain=1 then domain=0 and grant each in turn → head_domain reads 1 then 0; a stray grants_p0 while reqs_p2 is high causes no pop.
- Grant every cycle with continuous in_val → 1 msg/cycle and pointers wrap correctly over 8+ messages. Assert reset mid-stream → all reqs 0 and head_val 0 the next cycle.
- Bypass build: enqueue into an empty queue with a same-cycle grant → message consumed in that cycle and count stays 0.

Source files
------------

// File: rtl/plab4_net_router_input_ctrl_sep_pkg.sv
// Shared port indices and route helpers for the ring router.
// Used by input ctrl, output ctrls and crossbar decode.
package plab4_net_router_input_ctrl_sep_pkg;

  localparam logic [1:0] PORT_PREV = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_NEXT = 2'd2;

  function automatic int get_dest(
    input logic [63:0] msg,
    input int          msg_nbits,
    input int          dest_nbits
  );
    logic [63:0] sh;
    sh = msg >> (msg_nbits - dest_nbits);
    sh = sh & ((64'd1 << dest_nbits) - 64'd1);
    return int'(sh);
  endfunction

  // Forward ring distance; ties at n/2 go forward.
  function automatic logic [1:0] route(
    input int dest,
    input int id,
    input int n
  );
    int fwd;
    fwd = (dest - id + n) % n;
    if (fwd == 0)
      return PORT_TERM;
    else if (fwd <= n / 2)
      return PORT_NEXT;
    else
      return PORT_PREV;
  endfunction

endpackage

// File: rtl/plab4_net_router_input_queue.sv
// Circular queue with head/tail pointers and occupancy count.
// Head read port returns zero when empty.
import plab4_net_router_input_ctrl_sep_pkg::*;

module plab4_net_router_input_queue #(
  parameter int p_nbits       = 17,
  parameter int p_num_entries = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enq_val,
  input  logic [p_nbits-1:0] i_enq_data,
  input  logic               i_deq,
  output logic [p_nbits-1:0] o_head_data,
  output logic               o_empty,
  output logic               o_full
);

  localparam int PW = $clog2(p_num_entries);
  localparam int CW = $clog2(p_num_entries + 1);

  logic [p_nbits-1:0] r_mem [p_num_entries];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               w_enq;
  logic               w_deq;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(p_num_entries - 1)) ?
      '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(p_num_entries));
  assign w_enq   = i_enq_val && !o_full;
  assign w_deq   = i_deq && !o_empty;

  assign o_head_data = o_empty ?
    '0 : r_mem[r_head];

  always_ff @(posedge clk) begin
    if (w_enq && !reset)
      r_mem[r_tail] <= i_enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)
        r_tail <= nxt(r_tail);
      if (w_deq)
        r_head <= nxt(r_head);
      if (w_enq && !w_deq)
        r_count <= r_count + CW'(1);
      else if (w_deq && !w_enq)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Ring router input ctrl: queue, route compute, split reqs.
// Define PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN for 0-cycle bypass.
import plab4_net_router_input_ctrl_sep_pkg::*;

module plab4_net_router_input_ctrl_sep #(
  parameter int p_msg_nbits   = 16,
  parameter int p_dest_nbits  = 2,
  parameter int p_num_routers = 4,
  parameter int p_router_id   = 0,
  parameter int p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_domain,
  output logic                   reqs_p0,
  output logic                   reqs_p1,
  output logic                   reqs_p2,
  input  logic                   grants_p0,
  input  logic                   grants_p1,
  input  logic                   grants_p2,
  output logic [p_msg_nbits-1:0] head_msg,
  output logic                   head_domain,
  output logic                   head_val
);

  logic                 w_q_empty;
  logic                 w_q_full;
  logic [p_msg_nbits:0] w_q_head;
  logic                 w_byp;
  logic [1:0]           w_port;
  logic                 w_grant;
  logic                 w_deq;
  logic                 w_enq;

`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
  assign w_byp = w_q_empty && in_val;
`else
  assign w_byp = 1'b0;
`endif

  assign head_val = !w_q_empty || w_byp;
  assign {head_domain, head_msg} = w_byp ?
    {in_domain, in_msg} : w_q_head;

  assign w_port = route(
    get_dest(64'(head_msg), p_msg_nbits, p_dest_nbits),
    p_router_id, p_num_routers);

  assign reqs_p0 = head_val && (w_port == PORT_PREV);
  assign reqs_p1 = head_val && (w_port == PORT_TERM);
  assign reqs_p2 = head_val && (w_port == PORT_NEXT);

  // Only the requested port's grant can pop.
  assign w_grant = (reqs_p0 && grants_p0)
                || (reqs_p1 && grants_p1)
                || (reqs_p2 && grants_p2);

  assign w_deq  = w_grant && !w_q_empty;
  assign in_rdy = !reset && !w_q_full;
  assign w_enq  = in_val && in_rdy
               && !(w_byp && w_grant);

  plab4_net_router_input_queue #(
    .p_nbits      (p_msg_nbits + 1),
    .p_num_entries(p_num_entries)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .i_enq_val  (w_enq),
    .i_enq_data ({in_domain, in_msg}),
    .i_deq      (w_deq),
    .o_head_data(w_q_head),
    .o_empty    (w_q_empty),
    .o_full     (w_q_full)
  );

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Randomized bench for the ring router input ctrl.
// Reference model is a plain queue plus ring-distance arithmetic.
module tb_plab4_net_router_input_ctrl_sep;

  localparam int NR  = 4;
  localparam int ID  = 0;
  localparam int DEP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in_msg;
  logic        in_domain;
  logic        reqs_p0, reqs_p1, reqs_p2;
  logic        grants_p0, grants_p1, grants_p2;
  logic [15:0] head_msg;
  logic        head_domain;
  logic        head_val;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] msg;
    logic        dom;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  plab4_net_router_input_ctrl_sep #(
    .p_msg_nbits  (16),
    .p_dest_nbits (2),
    .p_num_routers(NR),
    .p_router_id  (ID),
    .p_num_entries(DEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .in_domain  (in_domain),
    .reqs_p0    (reqs_p0),
    .reqs_p1    (reqs_p1),
    .reqs_p2    (reqs_p2),
    .grants_p0  (grants_p0),
    .grants_p1  (grants_p1),
    .grants_p2  (grants_p2),
    .head_msg   (head_msg),
    .head_domain(head_domain),
    .head_val   (head_val)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Port index 0=prev, 1=term, 2=next from ring distance.
  function automatic int exp_port(input logic [15:0] m);
    int dest, fwd;
    dest = int'(m[15:14]);
    fwd  = (dest + NR - ID) % NR;
    if (fwd == 0) return 1;
    if (2 * fwd <= NR) return 2;
    return 0;
  endfunction

  task automatic run_cycle(
    input logic rst,
    input int   pin,
    input int   gmode
  );
    ent_t h;
    logic hv;
    int   p;
    logic [2:0] g;
    logic [2:0] exp_reqs;
    logic byp;
    logic popped;

    @(negedge clk);
    reset     = rst;
    in_val    = !rst && ($urandom_range(0, 99) < pin);
    in_msg    = 16'($urandom);
    in_domain = 1'($urandom);

    hv  = (q.size() > 0);
    byp = 1'b0;
`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
    if (!hv && in_val) begin
      hv  = 1'b1;
      byp = 1'b1;
    end
`endif
    if (byp) begin
      h.msg = in_msg;
      h.dom = in_domain;
    end else if (q.size() > 0) begin
      h = q[0];
    end else begin
      h.msg = '0;
      h.dom = 1'b0;
    end
    p = exp_port(h.msg);

    g = 3'b000;
    case (gmode)
      1, 3: if (hv) g[p] = 1'b1;
      2:    g[$urandom_range(0, 2)] = 1'b1;
      default: g = 3'b000;
    endcase
    {grants_p2, grants_p1, grants_p0} = g;

    #1;
    exp_reqs = hv ? (3'b001 << p) : 3'b000;
    chk("in_rdy", int'(in_rdy),
        int'(!rst && q.size() < DEP));
    chk("head_val", int'(head_val), int'(hv));
    chk("reqs", int'({reqs_p2, reqs_p1, reqs_p0}),
        int'(exp_reqs));
    chk("head_msg", int'(head_msg), int'(h.msg));
    chk("head_domain", int'(head_domain), int'(h.dom));

    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      popped = hv && g[p];
      if (byp) begin
        if (!popped) q.push_back(h);
      end else begin
        if (in_val && q.size() < DEP) begin
          h.msg = in_msg;
          h.dom = in_domain;
          q.push_back(h);
        end
        if (popped) void'(q.pop_front());
      end
    end
  endtask

  task automatic expect_popped_front(
    input logic was_nonempty,
    input int   old_size
  );
    if (was_nonempty)
      chk("size_track", q.size(), old_size);
  endtask

  initial begin
    reset = 1'b1;
    in_val = 1'b0;
    in_msg = '0;
    in_domain = 1'b0;
    grants_p0 = 1'b0;
    grants_p1 = 1'b0;
    grants_p2 = 1'b0;

    for (int i = 0; i < 3; i++) run_cycle(1'b1, 0, 0);

    // Fill without grants, then hold off extra valids.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 100, 0);
    // Stray grants only.
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 50, 2);
    // Full throughput: grant every cycle.
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 100, 1);
    // Mixed random traffic.
    for (int i = 0; i < 200; i++)
      run_cycle(1'b0, 70, int'($urandom_range(0, 3)));

    // Reset mid-stream flushes everything.
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 100, 0);
    run_cycle(1'b1, 0, 0);
    for (int i = 0; i < 200; i++)
      run_cycle(1'b0, int'($urandom_range(20, 100)),
                int'($urandom_range(0, 3)));
    run_cycle(1'b1, 0, 0);
    run_cycle(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
